// File: rtl/serial_parity_rx.sv
// Receiver for the XOR-parity serial link: start, DATA_W data bits LSB-first, parity, stop.
// Samples each bit at its centre, counted from the synchronised start edge.
module serial_parity_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic ODD_L = (ODD_PARITY != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t              state_q, state_d;
  logic                sync1_q, rx_s_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                acc_q, acc_d;
  logic                perr_q, perr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_out_q, perr_out_d;
  logic                ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      acc_q      <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= rx;
      rx_s_q     <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    perr_d     = perr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Mid-start re-check rejects short low glitches on the line
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            acc_d   = 1'b0;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = (shift_q >> 1) | (DATA_W'(rx_s_q) << (DATA_W - 1));
          acc_d   = acc_q ^ rx_s_q;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) state_d = PARITY;
        end
      end
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          perr_d  = (acc_q ^ rx_s_q) != ODD_L;
          state_d = STOP;
        end
      end
      STOP: begin
        // Leaving here half-way into the stop bit lets a new start edge follow with no gap
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          valid_d    = 1'b1;
          data_d     = shift_q;
          perr_out_d = perr_q;
          ferr_d     = !rx_s_q;
          state_d    = rx_s_q ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: directed frame table, multi-cycle corner sequences,
// and random frames checked against a frame-level reference model.
module tb_serial_parity_rx;
  localparam int DATA_W = 8;
  localparam int CPB    = 4;
  localparam int ODD    = 0;
  // 2 synchroniser cycles + HALF + 10 bit periods + 1 register cycle
  localparam int LAT    = 45;

  logic clk = 1'b0;
  logic rst, rx;
  logic [DATA_W-1:0] data_out;
  logic valid, parity_err, frame_err, busy;

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .ODD_PARITY(ODD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              p;
    logic              s;
    logic [DATA_W-1:0] ed;
    logic              ep;
    logic              ef;
  } vec_t;

  typedef struct {
    int                t;
    logic [DATA_W-1:0] d;
    logic              pe;
    logic              fe;
  } obs_t;

  obs_t got[$];
  obs_t expq[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (valid === 1'b1) got.push_back('{cyc, data_out, parity_err, frame_err});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s,
                            output int t0);
    t0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic wait_got(input int n, input string name);
    int k;
    k = 0;
    while (got.size() < n && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(name, got.size(), n);
  endtask

  task automatic pop_cmp(input string name, input logic [DATA_W-1:0] ed, input logic ep,
                         input logic ef, output obs_t o);
    if (got.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got no valid expected one", name);
      o = '{0, '0, 1'b0, 1'b0};
    end else begin
      o = got.pop_front();
      chk({name, " data"}, o.d, ed);
      chk({name, " perr"}, o.pe, ep);
      chk({name, " ferr"}, o.fe, ef);
    end
  endtask

  function automatic logic model_perr(input logic [DATA_W-1:0] d, input logic p);
    int ones;
    ones = $countones(d) + int'(p);
    return (ones % 2) != ODD;
  endfunction

  initial begin
    vec_t tbl[6];
    obs_t o, oa, ob;
    int t0, t1;
    logic busy_seen;
    logic [DATA_W-1:0] rd;
    logic rp, rs;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[4] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    tbl[5] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset data_out", data_out, 0);
    chk("reset valid", valid, 0);
    chk("reset parity_err", parity_err, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset busy", busy, 0);
    rst = 1'b0;
    idle_bits(2);

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].d, tbl[i].p, tbl[i].s, t0);
      if (!tbl[i].s) begin
        rx = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk($sformatf("tbl%0d valids during break", i), got.size(), 1);
        idle_bits(2);
      end else begin
        idle_bits(2);
      end
      wait_got(1, $sformatf("tbl%0d valid count", i));
      pop_cmp($sformatf("tbl%0d", i), tbl[i].ed, tbl[i].ep, tbl[i].ef, o);
      chk($sformatf("tbl%0d latency", i), o.t - t0, LAT);
    end

    // Single-cycle low glitch: busy pulses, nothing delivered, outputs hold
    busy_seen = 1'b0;
    rx = 1'b0;
    @(negedge clk);
    #1;
    rx = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    chk("glitch busy pulse", busy_seen, 1);
    chk("glitch no valid", got.size(), 0);
    chk("glitch data hold", data_out, tbl[5].ed);
    chk("glitch perr hold", parity_err, tbl[5].ep);
    chk("glitch ferr hold", frame_err, tbl[5].ef);

    // Back-to-back frames with no idle bit between them
    send_frame(8'h00, 1'b0, 1'b1, t0);
    send_frame(8'hFF, 1'b0, 1'b1, t1);
    idle_bits(2);
    wait_got(2, "b2b valid count");
    pop_cmp("b2b first", 8'h00, 1'b0, 1'b0, oa);
    pop_cmp("b2b second", 8'hFF, 1'b0, 1'b0, ob);
    chk("b2b spacing", ob.t - oa.t, 44);

    // Reset asserted during data bit 3
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst data_out", data_out, 0);
    chk("midrst valid", valid, 0);
    chk("midrst parity_err", parity_err, 0);
    chk("midrst frame_err", frame_err, 0);
    chk("midrst busy", busy, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    idle_bits(3);
    chk("midrst no valid", got.size(), 0);
    send_frame(8'h5A, 1'b0, 1'b1, t0);
    idle_bits(2);
    wait_got(1, "post-rst valid count");
    pop_cmp("post-rst", 8'h5A, 1'b0, 1'b0, o);

    // Random frames against the frame-level model
    for (int n = 0; n < 40; n++) begin
      rd = DATA_W'($urandom);
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 5) != 0);
      send_frame(rd, rp, rs, t0);
      expq.push_back('{t0 + LAT, rd, model_perr(rd, rp), !rs});
      if (!rs) begin
        rx = 1'b0;
        repeat ($urandom_range(0, 8)) @(negedge clk);
        #1;
        idle_bits(1 + $urandom_range(0, 1));
      end else begin
        idle_bits($urandom_range(0, 2));
      end
    end
    idle_bits(3);
    chk("random valid count", got.size(), expq.size());
    while (expq.size() > 0) begin
      obs_t e;
      e = expq.pop_front();
      pop_cmp("random", e.d, e.pe, e.fe, o);
      chk("random time", o.t, e.t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
